trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the data width of a CSR word and PC.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, the CSR register-file address width.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_trap_req  input  1  exception request, held by the requester until o_ack.
REQ-006 SHALL have i_trap_cause  input  DATA_WIDTH  cause code, valid with i_trap_req.
REQ-007 SHALL have i_trap_pc  input  DATA_WIDTH  PC of the faulting instruction, valid with i_trap_req.
REQ-008 SHALL have i_mret_req  input  1  return-from-trap request, held until o_ack.
REQ-009 SHALL have o_csr_write_en  output  1  CSR register-file write enable.
REQ-010 SHALL have o_csr_write_addr  output  ADDR_WIDTH  CSR write address.
REQ-011 SHALL have o_csr_write_data  output  DATA_WIDTH  CSR write data.
REQ-012 SHALL have o_csr_read_addr  output  ADDR_WIDTH  CSR read address.
REQ-013 SHALL have i_csr_read_data  input  DATA_WIDTH  CSR read data, combinational from o_csr_read_addr.
REQ-014 SHALL have o_ack  output  1  one-cycle pulse; the request is accepted.
REQ-015 SHALL have o_busy  output  1  high while a sequence is in progress; the core stalls on it.
REQ-016 SHALL have o_redirect_valid  output  1  one-cycle pulse; o_redirect_pc is valid.
REQ-017 SHALL have o_redirect_pc  output  DATA_WIDTH  new fetch PC.

Function
REQ-018 SHALL use CSR addresses MEPC=0, MCAUSE=1, MTVEC=2; address 3 SHALL never be driven.
REQ-019 SHALL implement FSM states IDLE, SAVE_EPC, SAVE_CAUSE, VECTOR, RET.
REQ-020 IDLE: on i_trap_req, SHALL pulse o_ack, register pc and cause, and go to SAVE_EPC.
REQ-021 IDLE: on i_mret_req without i_trap_req, SHALL pulse o_ack and go to RET; trap wins when both are requested.
REQ-022 SAVE_EPC: SHALL set write_en=1, addr=MEPC, data=registered pc, then go to SAVE_CAUSE.
REQ-023 SAVE_CAUSE: SHALL set write_en=1, addr=MCAUSE, data=registered cause, then go to VECTOR.
REQ-024 VECTOR: SHALL set read_addr=MTVEC; redirect_pc={read_data[DW-1:2],2'b00}; redirect_valid=1; then go to IDLE.
REQ-025 RET: SHALL set read_addr=MEPC; redirect_pc=read_data; redirect_valid=1; then go to IDLE.
REQ-026 Latency: a trap accepted in cycle N SHALL redirect in N+3; an mret accepted in cycle N SHALL redirect in N+1.
REQ-027 o_busy SHALL equal (state != IDLE); requests arriving while busy SHALL be ignored, with no ack and no capture.
REQ-028 Outside the write states, write_en, write_addr and write_data SHALL be 0; outside VECTOR, read_addr SHALL be MEPC; outside VECTOR and RET, redirect_pc SHALL be 0.
REQ-029 The registered pc and cause SHALL change only on trap acceptance.

Reset
REQ-030 arstn low SHALL immediately force state IDLE, all outputs 0, and registered pc and cause 0.
REQ-031 Reset mid-sequence SHALL abort the sequence; no further CSR write or redirect SHALL occur after reset release until a new request arrives.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the CSR address constants MEPC, MCAUSE and MTVEC.
REQ-033 The block SHALL be a single module with no sub-module, connected point-to-point to the CSR register file.

Verification
REQ-034 Trap (pc=0x1000, cause=0x2), mtvec=0x8001 -> ack in cycle N; writes MEPC=0x1000 at N+1 and MCAUSE=0x2 at N+2; redirect 0x8000 at N+3.
REQ-035 mret with mepc=0x1000 -> ack in cycle N; redirect 0x1000 at N+1; no CSR write.
REQ-036 trap and mret asserted in the same cycle -> the trap sequence runs; mret is acked only after return to IDLE.
REQ-037 Second trap asserted during SAVE_CAUSE -> no ack and no capture; the first sequence's writes are unchanged.
REQ-038 arstn low during SAVE_EPC -> outputs 0 at once; no MCAUSE write and no redirect after release.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap controller: the sequencing
// FSM state type and the CSR register-file addresses it reads and writes.
// No ports; imported by trap_ctrl.

package trap_ctrl_pkg;

  // Sequencing states of the trap controller
  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    VECTOR,
    RET
  } state_t;

  // CSR register-file addresses; address 3 is deliberately unused
  localparam int unsigned MEPC   = 0;
  localparam int unsigned MCAUSE = 1;
  localparam int unsigned MTVEC  = 2;

endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl
// Machine-mode trap controller. Accepts an exception request or a
// return-from-trap request while idle, saves the faulting PC and cause into
// the CSR register file, then redirects fetch to the trap vector (or, for
// mret, back to the saved PC).
//
// Ports:
//   clk, arstn            clock, asynchronous active-low reset
//   i_trap_req            exception request, held until o_ack
//   i_trap_cause          cause code, valid with i_trap_req
//   i_trap_pc             faulting PC, valid with i_trap_req
//   i_mret_req            return-from-trap request, held until o_ack
//   o_csr_write_en/addr/data  CSR register-file write port
//   o_csr_read_addr       CSR register-file read address
//   i_csr_read_data       CSR read data, combinational from o_csr_read_addr
//   o_ack                 one-cycle accept pulse
//   o_busy                high while a sequence is in progress
//   o_redirect_valid      one-cycle pulse qualifying o_redirect_pc
//   o_redirect_pc         new fetch PC

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_trap_req,
  input  logic [DATA_WIDTH-1:0] i_trap_cause,
  input  logic [DATA_WIDTH-1:0] i_trap_pc,
  input  logic                  i_mret_req,
  output logic                  o_csr_write_en,
  output logic [ADDR_WIDTH-1:0] o_csr_write_addr,
  output logic [DATA_WIDTH-1:0] o_csr_write_data,
  output logic [ADDR_WIDTH-1:0] o_csr_read_addr,
  input  logic [DATA_WIDTH-1:0] i_csr_read_data,
  output logic                  o_ack,
  output logic                  o_busy,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc
);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_cause;
  logic                  w_accept_trap;
  logic                  w_accept_mret;

  // Requests are only looked at in IDLE; a trap has priority over mret
  assign w_accept_trap = (r_state == IDLE) && i_trap_req;
  assign w_accept_mret = (r_state == IDLE) && i_mret_req && !i_trap_req;

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Captured PC and cause are only updated when a trap is accepted, so a
  // request raised while busy cannot disturb the sequence in flight
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_pc    <= '0;
      r_cause <= '0;
    end else if (w_accept_trap) begin
      r_pc    <= i_trap_pc;
      r_cause <= i_trap_cause;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept_trap) begin
          w_next_state = SAVE_EPC;
        end else if (w_accept_mret) begin
          w_next_state = RET;
        end
      end
      SAVE_EPC:   w_next_state = SAVE_CAUSE;
      SAVE_CAUSE: w_next_state = VECTOR;
      VECTOR:     w_next_state = IDLE;
      RET:        w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // Output logic. Everything defaults to zero with the read port parked on
  // MEPC; the ack is gated by arstn so it stays low while reset is asserted
  // even if a requester is holding its request.
  always_comb begin
    o_csr_write_en   = 1'b0;
    o_csr_write_addr = '0;
    o_csr_write_data = '0;
    o_csr_read_addr  = ADDR_WIDTH'(MEPC);
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_ack            = arstn && (w_accept_trap || w_accept_mret);
    o_busy           = (r_state != IDLE);
    case (r_state)
      SAVE_EPC: begin
        o_csr_write_en   = 1'b1;
        o_csr_write_addr = ADDR_WIDTH'(MEPC);
        o_csr_write_data = r_pc;
      end
      SAVE_CAUSE: begin
        o_csr_write_en   = 1'b1;
        o_csr_write_addr = ADDR_WIDTH'(MCAUSE);
        o_csr_write_data = r_cause;
      end
      VECTOR: begin
        // Direct mode only: the low two mode bits of mtvec are dropped
        o_csr_read_addr  = ADDR_WIDTH'(MTVEC);
        o_redirect_valid = 1'b1;
        o_redirect_pc    = {i_csr_read_data[DATA_WIDTH-1:2], 2'b00};
      end
      RET: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = i_csr_read_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl
// Self-checking bench for trap_ctrl. A stimulus process drives trap/mret
// requests (directed scenarios, then random traffic with occasional resets)
// and a transaction-level model schedules the expected ack, CSR writes and
// redirect into a queue; a separate monitor pops and compares whenever the
// DUT presents one of those events. A behavioural CSR register file is
// attached to the DUT's CSR ports.

module tb_trap_ctrl;

  localparam int DW = 64;
  localparam int AW = 2;

  // Expected event kinds
  localparam int EV_ACK   = 0;
  localparam int EV_WRITE = 1;
  localparam int EV_REDIR = 2;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          i_trap_req = 1'b0;
  logic [DW-1:0] i_trap_cause = '0;
  logic [DW-1:0] i_trap_pc = '0;
  logic          i_mret_req = 1'b0;
  logic          o_csr_write_en;
  logic [AW-1:0] o_csr_write_addr;
  logic [DW-1:0] o_csr_write_data;
  logic [AW-1:0] o_csr_read_addr;
  logic [DW-1:0] i_csr_read_data;
  logic          o_ack;
  logic          o_busy;
  logic          o_redirect_valid;
  logic [DW-1:0] o_redirect_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  trap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .arstn            (arstn),
    .i_trap_req       (i_trap_req),
    .i_trap_cause     (i_trap_cause),
    .i_trap_pc        (i_trap_pc),
    .i_mret_req       (i_mret_req),
    .o_csr_write_en   (o_csr_write_en),
    .o_csr_write_addr (o_csr_write_addr),
    .o_csr_write_data (o_csr_write_data),
    .o_csr_read_addr  (o_csr_read_addr),
    .i_csr_read_data  (i_csr_read_data),
    .o_ack            (o_ack),
    .o_busy           (o_busy),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CSR register file; the bench can preload it while the DUT
  // is not writing
  logic [DW-1:0] csrFile [0:3];
  logic          tbWrEn = 1'b0;
  logic [AW-1:0] tbWrAddr = '0;
  logic [DW-1:0] tbWrData = '0;

  always @(posedge clk) begin
    if (o_csr_write_en) csrFile[o_csr_write_addr] <= o_csr_write_data;
    else if (tbWrEn) csrFile[tbWrAddr] <= tbWrData;
  end

  assign i_csr_read_data = csrFile[o_csr_read_addr];

  // Reference model: accepted transactions expand into timed events
  typedef struct {
    int            cyc;
    int            kind;
    int            addr;
    logic [DW-1:0] data;
  } expEvent_t;

  expEvent_t expQ[$];

  int            busyUntil = -1;
  int            lastAccept = -1;
  int            vectorCyc = -1;
  int            mepcCommitCyc = -1;
  logic [DW-1:0] modelMepc = '0;
  logic [DW-1:0] prevMepc = '0;
  logic [DW-1:0] modelMtvec = '0;
  bit            dropTrap = 1'b0;
  bit            dropMret = 1'b0;

  function automatic bit modelBusy(int c);
    return (c > lastAccept) && (c <= busyUntil);
  endfunction

  function automatic void pushEvent(int c, int k, int a, logic [DW-1:0] d);
    expEvent_t e;
    e.cyc  = c;
    e.kind = k;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  // Evaluate the model for the current cycle with the inputs now applied.
  // The controller is free once the previous sequence's last cycle is over.
  task automatic modelStep();
    int c;
    c = cyc;
    if (arstn && c > busyUntil) begin
      if (i_trap_req) begin
        pushEvent(c, EV_ACK, 0, '0);
        pushEvent(c + 1, EV_WRITE, 0, i_trap_pc);
        pushEvent(c + 2, EV_WRITE, 1, i_trap_cause);
        pushEvent(c + 3, EV_REDIR, 0, modelMtvec & ~(DW'(3)));
        prevMepc      = modelMepc;
        modelMepc     = i_trap_pc;
        mepcCommitCyc = c + 1;
        lastAccept    = c;
        busyUntil     = c + 3;
        vectorCyc     = c + 3;
        dropTrap      = 1'b1;
      end else if (i_mret_req) begin
        pushEvent(c, EV_ACK, 0, '0);
        pushEvent(c + 1, EV_REDIR, 0, modelMepc);
        lastAccept = c;
        busyUntil  = c + 1;
        dropMret   = 1'b1;
      end
    end
  endtask

  // One cycle of requester behaviour: drop requests acked last cycle, raise
  // any newly wanted ones (held until acked), then run the model
  task automatic applyStimulus(bit newTrap, bit newMret, logic [DW-1:0] pc, logic [DW-1:0] cause);
    @(negedge clk);
    if (dropTrap) begin i_trap_req = 1'b0; dropTrap = 1'b0; end
    if (dropMret) begin i_mret_req = 1'b0; dropMret = 1'b0; end
    if (newTrap && !i_trap_req) begin
      i_trap_req   = 1'b1;
      i_trap_pc    = pc;
      i_trap_cause = cause;
    end
    if (newMret && !i_mret_req) i_mret_req = 1'b1;
    if (!i_trap_req) begin
      i_trap_pc    = {$urandom, $urandom};
      i_trap_cause = {$urandom, $urandom};
    end
    modelStep();
  endtask

  task automatic idleCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic writeCsr(logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    tbWrEn   = 1'b1;
    tbWrAddr = a;
    tbWrData = d;
    @(negedge clk);
    tbWrEn   = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs collapse at once, and discard
  // everything the model had scheduled from this cycle on
  task automatic applyReset(int holdCycles);
    expEvent_t keep[$];
    int c;
    @(negedge clk);
    arstn      = 1'b0;
    i_trap_req = 1'b0;
    i_mret_req = 1'b0;
    dropTrap   = 1'b0;
    dropMret   = 1'b0;
    c = cyc;
    foreach (expQ[i]) if (expQ[i].cyc < c) keep.push_back(expQ[i]);
    expQ = keep;
    if (mepcCommitCyc >= c) modelMepc = prevMepc;
    busyUntil     = -1;
    lastAccept    = -1;
    vectorCyc     = -1;
    mepcCommitCyc = -1;
    #1;
    checkOutput("resetAck", DW'(o_ack), '0);
    checkOutput("resetBusy", DW'(o_busy), '0);
    checkOutput("resetWrEn", DW'(o_csr_write_en), '0);
    checkOutput("resetWrAddr", DW'(o_csr_write_addr), '0);
    checkOutput("resetWrData", o_csr_write_data, '0);
    checkOutput("resetRdAddr", DW'(o_csr_read_addr), '0);
    checkOutput("resetRedirValid", DW'(o_redirect_valid), '0);
    checkOutput("resetRedirPc", o_redirect_pc, '0);
    repeat (holdCycles) @(negedge clk);
    arstn = 1'b1;
  endtask

  // Monitor: compares every presented event against the scoreboard and the
  // quiet-value rules on every cycle out of reset
  expEvent_t     monE;
  int            nPresent;
  int            actKind;
  logic [DW-1:0] actData;

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (arstn) begin
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
          monE = expQ.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missingEvent cycle %0d actual none required kind %0d at cycle %0d data %h",
                   cyc, monE.kind, monE.cyc, monE.data);
        end
        nPresent = int'(o_ack) + int'(o_csr_write_en) + int'(o_redirect_valid);
        if (nPresent > 1) begin
          checks++;
          errors++;
          $display("[TB] FAIL overlapEvent cycle %0d actual ack=%b we=%b rv=%b required at most one",
                   cyc, o_ack, o_csr_write_en, o_redirect_valid);
        end else if (nPresent == 1) begin
          actKind = o_ack ? EV_ACK : (o_csr_write_en ? EV_WRITE : EV_REDIR);
          actData = o_csr_write_en ? o_csr_write_data : (o_redirect_valid ? o_redirect_pc : '0);
          if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedEvent cycle %0d actual kind %0d data %h required no event",
                     cyc, actKind, actData);
          end else begin
            monE = expQ.pop_front();
            checkOutput("eventKind", DW'(actKind), DW'(monE.kind));
            checkOutput("eventAddr", DW'(o_csr_write_addr), DW'(monE.addr));
            checkOutput("eventData", actData, monE.data);
          end
        end
        checkOutput("busy", DW'(o_busy), DW'(modelBusy(cyc)));
        checkOutput("readAddr", DW'(o_csr_read_addr), (cyc == vectorCyc) ? DW'(2) : DW'(0));
        if (!o_csr_write_en) begin
          checkOutput("quietWrAddr", DW'(o_csr_write_addr), '0);
          checkOutput("quietWrData", o_csr_write_data, '0);
        end
        if (!o_redirect_valid) checkOutput("quietRedirPc", o_redirect_pc, '0);
      end
    end
  end

  int r;

  initial begin : stimulus
    // Reset state, then preload the CSR file while still in reset
    @(negedge clk);
    #2;
    checkOutput("initAck", DW'(o_ack), '0);
    checkOutput("initBusy", DW'(o_busy), '0);
    checkOutput("initRedirValid", DW'(o_redirect_valid), '0);
    checkOutput("initWrEn", DW'(o_csr_write_en), '0);
    writeCsr(2'd0, '0);
    writeCsr(2'd1, '0);
    writeCsr(2'd2, 64'h8001);
    modelMepc  = '0;
    modelMtvec = 64'h8001;
    @(negedge clk);
    arstn = 1'b1;
    idleCycles(2);

    // Trap: MEPC and MCAUSE writes, then vector with mode bits cleared
    applyStimulus(1'b1, 1'b0, 64'h1000, 64'h2);
    idleCycles(5);

    // mret back to the saved PC, no CSR write
    applyStimulus(1'b0, 1'b1, '0, '0);
    idleCycles(3);

    // Trap and mret together: trap first, mret acked once idle again
    applyStimulus(1'b1, 1'b1, 64'h2000, 64'h5);
    idleCycles(8);

    // Second trap raised during SAVE_CAUSE is ignored until idle
    applyStimulus(1'b1, 1'b0, 64'h3000, 64'h7);
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 64'h4444, 64'hB);
    idleCycles(8);

    // Reset during SAVE_EPC aborts the sequence
    applyStimulus(1'b1, 1'b0, 64'h5000, 64'h3);
    applyReset(2);
    idleCycles(6);

    // Random traffic with a fresh trap vector and occasional resets
    writeCsr(2'd2, {$urandom, $urandom});
    modelMtvec = tbWrData;
    idleCycles(2);
    for (int k = 0; k < 500; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) applyReset(1 + int'($urandom_range(0, 1)));
      else applyStimulus(r < 30, (r >= 25) && (r < 40), {$urandom, $urandom}, {$urandom, $urandom});
    end
    idleCycles(10);

    checkOutput("queueDrained", DW'(expQ.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
